seg7_scan_driver: RTL and testbench

Time-multiplexed driver for the board's four-digit common-anode seven-segment display. It sits directly downstream of the 1 Hz down-counter stage and turns the counter value into visible digits. It latches a 16-bit word of four hex nibbles on a load strobe, then scans one digit per refresh slot. Leading-zero suppression and decimal points are optional.

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/hex_to_seg7.sv | 19 +
 rtl/seg7_scan_driver.sv | 107 ++++++++++
 tb/tb_seg7_scan_driver.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants for the seven-segment display drivers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

    localparam int         IDX_W     = 2;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low {g,f,e,d,c,b,a}; element n is the pattern for hex digit n.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

`default_nettype wire

// File: rtl/hex_to_seg7.sv
// ============================================================================
// Module      : hex_to_seg7
// Description : Combinational nibble to active-low seven-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[nib];

endmodule

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// ============================================================================
// Module      : seg7_scan_driver
// Description : Four-digit multiplexed seven-segment driver with optional
//               leading-zero blanking and decimal points.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] din,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int               CNT_W      = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [15:0]      r_dat;
    logic [3:0]       r_dpl;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;

    logic [3:0]       w_nib;
    logic [6:0]       w_dec_seg;
    logic [3:0]       w_zero;
    logic [3:0]       w_lead_zero;
    logic             w_blank;
    logic [3:0]       w_an;
    logic [6:0]       w_seg;
    logic             w_dp;

    for (genvar k = 0; k < 4; k++) begin : g_zero
        assign w_zero[k] = (r_dat[4*k +: 4] == 4'h0);
    end

    // Digit k is a leading zero only if it and every digit above it are zero.
    assign w_lead_zero[3] = w_zero[3];
    assign w_lead_zero[2] = w_zero[3] & w_zero[2];
    assign w_lead_zero[1] = w_zero[3] & w_zero[2] & w_zero[1];
    assign w_lead_zero[0] = 1'b0;

    assign w_nib   = r_dat[{r_idx, 2'b00} +: 4];
    assign w_blank = blank_lz & w_lead_zero[r_idx];

    hex_to_seg7 u_dec (
        .nib (w_nib),
        .seg (w_dec_seg)
    );

    always_comb begin
        w_an  = AN_OFF;
        w_seg = SEG_BLANK;
        w_dp  = 1'b1;
        if (en) begin
            w_an  = ~(4'b0001 << r_idx);
            w_seg = w_blank ? SEG_BLANK : w_dec_seg;
            w_dp  = ~r_dpl[r_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_dat <= '0;
            r_dpl <= '0;
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            if (r_cnt == c_cnt_last) begin
                r_cnt <= '0;
                r_idx <= r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (load) begin
                r_dat <= din;
                r_dpl <= dp_in;
            end
            r_an  <= w_an;
            r_seg <= w_seg;
            r_dp  <= w_dp;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Self-checking bench for seg7_scan_driver with REFRESH_DIV=4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;

    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        reset, en, load, blank_lz;
    logic [15:0] din;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    seg7_scan_driver #(.REFRESH_DIV(RD)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .load     (load),
        .din      (din),
        .dp_in    (dp_in),
        .blank_lz (blank_lz),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    logic [6:0] ref_seg [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference model: time since reset, latched word, expected outputs.
    int          m_t;
    logic [15:0] m_dat;
    logic [3:0]  m_dpl;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    int          e_k;
    logic        e_on;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0]      din;
        logic [3:0]       dp;
        logic             blz;
        logic [3:0][6:0]  seg;
        logic [3:0]       dpo;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got an/seg/dp=%b_%b_%b want %b_%b_%b", name, $time,
                     act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    task automatic tick();
        logic [15:0] upper;
        @(posedge clk);
        if (reset) begin
            m_t = 0; m_dat = '0; m_dpl = '0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_on = 1'b0; e_k = 0;
        end else begin
            e_k   = (m_t / RD) % 4;
            upper = m_dat >> (4 * e_k);
            e_on  = en;
            if (!en) begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                e_an  = ~(4'b0001 << e_k);
                e_seg = (blank_lz && e_k != 0 && upper == 16'h0) ? 7'h7F : ref_seg[upper[3:0]];
                e_dp  = ~m_dpl[e_k];
            end
            m_t++;
            if (load) begin
                m_dat = din;
                m_dpl = dp_in;
            end
        end
        #1;
        chk("model", {an, seg, dp}, {e_an, e_seg, e_dp});
    endtask

    initial begin
        tbl[0] = '{16'h09AF, 4'b0000, 1'b0, {7'b1000000, 7'b0010000, 7'b0001000, 7'b0001110}, 4'b1111};
        tbl[1] = '{16'h0007, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'b1111000}, 4'b1111};
        tbl[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b1111};
        tbl[3] = '{16'h1234, 4'b0100, 1'b0, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1011};
        tbl[4] = '{16'h0102, 4'b0001, 1'b1, {7'h7F, 7'b1111001, 7'b1000000, 7'b0100100}, 4'b1110};
        tbl[5] = '{16'h0000, 4'b1000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b0111};

        reset = 1'b1; en = 1'b1; load = 1'b0; din = '0; dp_in = '0; blank_lz = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("reset_state", {an, seg, dp}, {4'b1111, 7'h7F, 1'b1});

        // Release: digit 0 shows zero on the first edge, then the scan steps.
        reset = 1'b0;
        tick();
        chk("first_edge", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
        for (int i = 0; i < 4 * RD + 3; i++) tick();

        // Table loads: after the load edge, check a full frame per digit.
        for (int v = 0; v < 6; v++) begin
            din = tbl[v].din; dp_in = tbl[v].dp; blank_lz = tbl[v].blz; load = 1'b1;
            tick();
            load = 1'b0;
            for (int c = 0; c < 4 * RD; c++) begin
                tick();
                chk($sformatf("table%0d_digit%0d", v, e_k), {an, seg, dp},
                    {~(4'b0001 << e_k), tbl[v].seg[e_k], tbl[v].dpo[e_k]});
            end
        end

        // Enable drop mid-frame: anodes off next edge, scan keeps counting.
        en = 1'b0;
        tick();
        chk("en_off", {an, seg, dp}, {4'b1111, 7'h7F, 1'b1});
        tick(); tick();
        en = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // Load on the slot boundary: new digit appears with new data.
        blank_lz = 1'b0;
        while ((m_t % RD) != RD - 1) tick();
        din = 16'h5555; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        chk("boundary_load", {an[3:0] == 4'hF, seg, dp}, {1'b0, 7'b0010010, 1'b1});

        // Reset while digit 2 is in its slot with all-F data.
        din = 16'hFFFF; load = 1'b1;
        tick();
        load = 1'b0;
        while (((m_t / RD) % 4) != 2) tick();
        tick();
        reset = 1'b1; load = 1'b1; din = 16'h1111;
        tick();
        chk("reset_mid_scan", {an, seg, dp}, {4'b1111, 7'h7F, 1'b1});
        reset = 1'b0; load = 1'b0;
        tick();
        chk("after_reset", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 59) == 0);
            load     = ($urandom_range(0, 5) == 0);
            din      = 16'($urandom >> $urandom_range(16, 31));
            dp_in    = 4'($urandom);
            en       = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
